// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: sequencer states, instruction
// classes, condition codes and flag bit positions.
package cpu_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_EQ = 4'h1;
  localparam logic [3:0] CC_NE = 4'h2;
  localparam logic [3:0] CC_CS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_MI = 4'h5;
  localparam logic [3:0] CC_PL = 4'h6;
  localparam logic [3:0] CC_VS = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Classes whose writeback drives the destination register.
  function automatic logic writes_reg(input logic [1:0] op);
    return (op == OP_ALU) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition check: does the instruction's condition field
// pass against the current {N,Z,C,V} flags. Codes 9..15 never pass.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_AL:   pass = 1'b1;
      CC_EQ:   pass =  flags[FLAG_Z];
      CC_NE:   pass = ~flags[FLAG_Z];
      CC_CS:   pass =  flags[FLAG_C];
      CC_CC:   pass = ~flags[FLAG_C];
      CC_MI:   pass =  flags[FLAG_N];
      CC_PL:   pass = ~flags[FLAG_N];
      CC_VS:   pass =  flags[FLAG_V];
      CC_VC:   pass = ~flags[FLAG_V];
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control FSM: fetch, decode/condition check, execute and
// writeback, with the program counter and retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [1:0]       op_class,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [3:0]       flags,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             rom_en,
  output logic             alu_en,
  output logic             ram_ce,
  output logic             ram_rw,
  output logic             reg_we,
  output logic             flag_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic             pass;
  logic [2:0]       state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] retired_nxt;
  logic             rom_en_nxt;
  logic             alu_en_nxt;
  logic             ram_ce_nxt;
  logic             ram_rw_nxt;
  logic             reg_we_nxt;
  logic             flag_we_nxt;

  logic [1:0]       op_class_p1;
  logic             set_flags_p1;
  logic [PC_W-1:0]  target_p1;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .pass  (pass)
  );

  // Decode fields are only guaranteed in DECODE; hold them for execute/writeback.
  always_ff @(posedge clock) begin
    if (state == S_DECODE) begin
      op_class_p1  <= op_class;
      set_flags_p1 <= set_flags;
      target_p1    <= branch_target;
    end
  end

  // Next-state and next-strobe logic; strobes are registered with the state
  // so every output is a flop.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    retired_nxt = retired;
    rom_en_nxt  = 1'b0;
    alu_en_nxt  = 1'b0;
    ram_ce_nxt  = 1'b0;
    ram_rw_nxt  = 1'b1;
    reg_we_nxt  = 1'b0;
    flag_we_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt  = S_FETCH;
          rom_en_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (pass) begin
          state_nxt  = S_EXECUTE;
          alu_en_nxt = 1'b1;
          ram_ce_nxt = (op_class == OP_LOAD);
        end else begin
          pc_nxt     = pc + PC_W'(1);
          state_nxt  = S_FETCH;
          rom_en_nxt = 1'b1;
        end
      end
      S_EXECUTE: begin
        state_nxt  = S_WRITEBACK;
        reg_we_nxt = writes_reg(op_class_p1);
        case (op_class_p1)
          OP_ALU:   flag_we_nxt = set_flags_p1;
          OP_STORE: begin
            ram_ce_nxt = 1'b1;
            ram_rw_nxt = 1'b0;
          end
          default: ;
        endcase
      end
      S_WRITEBACK: begin
        retired_nxt = retired + CNT_W'(1);
        pc_nxt      = (op_class_p1 == OP_BRANCH) ? target_p1 : pc + PC_W'(1);
        if (halt_req) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt  = S_FETCH;
          rom_en_nxt = 1'b1;
        end
      end
      S_HALT: ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      retired <= '0;
      rom_en  <= 1'b0;
      alu_en  <= 1'b0;
      ram_ce  <= 1'b0;
      ram_rw  <= 1'b1;
      reg_we  <= 1'b0;
      flag_we <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      retired <= retired_nxt;
      rom_en  <= rom_en_nxt;
      alu_en  <= alu_en_nxt;
      ram_ce  <= ram_ce_nxt;
      ram_rw  <= ram_rw_nxt;
      reg_we  <= reg_we_nxt;
      flag_we <= flag_we_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model expands each issued
// instruction into its expected per-cycle outputs, checked every cycle.
module tb_cpu_sequencer;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, STORE = 2'b10, BRANCH = 2'b11;

  logic             clock = 1'b0;
  logic             reset;
  logic             run;
  logic             halt_req;
  logic [1:0]       op_class;
  logic [3:0]       cond;
  logic             set_flags;
  logic [3:0]       flags;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  pc;
  logic             rom_en, alu_en, ram_ce, ram_rw, reg_we, flag_we;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .halt_req      (halt_req),
    .op_class      (op_class),
    .cond          (cond),
    .set_flags     (set_flags),
    .flags         (flags),
    .branch_target (branch_target),
    .pc            (pc),
    .rom_en        (rom_en),
    .alu_en        (alu_en),
    .ram_ce        (ram_ce),
    .ram_rw        (ram_rw),
    .reg_we        (reg_we),
    .flag_we       (flag_we),
    .state         (state),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int               c;
    logic [2:0]       st;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ret;
    logic [5:0]       stb;   // {rom_en, alu_en, ram_ce, ram_rw, reg_we, flag_we}
  } rec_t;

  rec_t q[$];
  int errors = 0;
  int checks = 0;

  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_ret;
  int next_cyc;

  // Condition rule: codes 1..8 pair up as (Z,!Z),(C,!C),(N,!N),(V,!V).
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic [3:0] order;
    int k;
    if (c == 4'd0) return 1'b1;
    if (c > 4'd8) return 1'b0;
    order = {f[2], f[1], f[3], f[0]};
    k = (int'(c) - 1) / 2;
    return order[3-k] ^ (((int'(c) - 1) % 2) == 1);
  endfunction

  task automatic push(input int c, input logic [2:0] st, input logic [5:0] stb);
    rec_t r;
    r.c = c; r.st = st; r.pc = m_pc; r.ret = m_ret; r.stb = stb;
    q.push_back(r);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Issue one instruction whose FETCH lands on cycle next_cyc; returns on the
  // cycle after its last state (next FETCH, or first HALT cycle).
  task automatic run_instr(input logic [1:0] op, input logic [3:0] cc, input logic sf,
                           input logic [3:0] fl, input logic [PC_W-1:0] tgt, input logic hr);
    int f;
    f = next_cyc;
    op_class = op; cond = cc; set_flags = sf; flags = fl;
    branch_target = tgt; halt_req = hr;
    push(f,     3'd1, 6'b100100);
    push(f + 1, 3'd2, 6'b000100);
    if (!cond_ok(cc, fl)) begin
      m_pc = m_pc + 1'b1;
      next_cyc = f + 2;
    end else begin
      push(f + 2, 3'd3, {2'b01, op == LOAD, 3'b100});
      push(f + 3, 3'd4, {2'b00, op == STORE, op != STORE,
                         (op == ALU) || (op == LOAD), (op == ALU) && sf});
      m_ret = m_ret + 1'b1;
      m_pc  = (op == BRANCH) ? tgt : m_pc + 1'b1;
      next_cyc = f + 4;
    end
    wait_cyc(next_cyc);
  endtask

  always @(negedge clock) begin
    rec_t r;
    if (q.size() > 0 && q[0].c <= cyc) begin
      r = q.pop_front();
      checks++;
      if (r.c != cyc ||
          {state, pc, retired, rom_en, alu_en, ram_ce, ram_rw, reg_we, flag_we} !==
          {r.st, r.pc, r.ret, r.stb}) begin
        errors++;
        $display("FAIL trace cyc=%0d(exp %0d) got st=%0d pc=%0h ret=%0d stb=%b expected st=%0d pc=%0h ret=%0d stb=%b",
                 cyc, r.c, state, pc, retired,
                 {rom_en, alu_en, ram_ce, ram_rw, reg_we, flag_we},
                 r.st, r.pc, r.ret, r.stb);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  logic [1:0] t_op [10] = '{ALU, LOAD, ALU, STORE, ALU, ALU, LOAD, ALU, ALU, ALU};
  logic [3:0] t_cc [10] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'h0};
  logic [3:0] t_fl [10] = '{4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                            4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b1111};
  logic       t_sf [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int f;
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; op_class = ALU; cond = 4'h0;
    set_flags = 1'b0; flags = 4'h0; branch_target = '0;
    m_pc = '0; m_ret = '0;
    wait_cyc(3);
    chk("reset_state", state, 3'd0);
    chk("reset_pc", pc, 8'h00);
    chk("reset_retired", retired, 16'd0);
    chk("reset_strobes", {rom_en, alu_en, ram_ce, ram_rw, reg_we, flag_we}, 6'b000100);
    reset = 1'b0;
    push(cyc + 1, 3'd0, 6'b000100);
    wait_cyc(cyc + 1);
    run = 1'b1;
    next_cyc = cyc + 1;

    // ALU always with flag update
    run_instr(ALU, 4'h0, 1'b1, 4'h0, '0, 1'b0);
    chk("alu_pc", pc, 8'h01);
    chk("alu_retired", retired, 16'd1);
    // STORE on Z, passing then failing
    run_instr(STORE, 4'h1, 1'b0, 4'b0100, '0, 1'b0);
    chk("store_pc", pc, 8'h02);
    run_instr(STORE, 4'h1, 1'b0, 4'b0000, '0, 1'b0);
    chk("skip_pc", pc, 8'h03);
    chk("skip_retired", retired, 16'd2);

    for (int i = 0; i < 10; i++) run_instr(t_op[i], t_cc[i], t_sf[i], t_fl[i], '0, 1'b0);

    run_instr(BRANCH, 4'h0, 1'b0, 4'h0, 8'h05, 1'b0);
    run_instr(BRANCH, 4'h0, 1'b0, 4'h0, 8'h20, 1'b0);
    chk("branch_pc", pc, 8'h20);
    run_instr(BRANCH, 4'h2, 1'b0, 4'b0100, 8'h77, 1'b0);
    chk("branch_skip_pc", pc, 8'h21);
    run_instr(BRANCH, 4'h0, 1'b0, 4'h0, 8'hFF, 1'b0);
    run_instr(ALU, 4'h0, 1'b0, 4'h0, '0, 1'b0);
    chk("wrap_pc", pc, 8'h00);
    run_instr(BRANCH, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("loop_pc", pc, 8'h00);

    // Halt after this instruction; run stays high and must be ignored
    run_instr(LOAD, 4'h0, 1'b0, 4'h0, '0, 1'b1);
    for (int i = 0; i < 10; i++) push(next_cyc + i, 3'd5, 6'b000100);
    wait_cyc(next_cyc + 9);
    chk("halt_state", state, 3'd5);
    chk("halt_retired", retired, m_ret);
    reset = 1'b1;
    m_pc = '0; m_ret = '0;
    push(cyc + 1, 3'd0, 6'b000100);
    wait_cyc(cyc + 1);
    reset = 1'b0; run = 1'b0; halt_req = 1'b0;
    chk("halt_reset_pc", pc, 8'h00);
    chk("halt_reset_retired", retired, 16'd0);
    push(cyc + 1, 3'd0, 6'b000100);
    push(cyc + 2, 3'd0, 6'b000100);
    wait_cyc(cyc + 2);

    // Reset landing in the EXECUTE of a LOAD
    run = 1'b1;
    next_cyc = cyc + 1;
    run_instr(ALU, 4'h0, 1'b0, 4'h0, '0, 1'b0);
    f = next_cyc;
    op_class = LOAD; cond = 4'h0; flags = 4'h0;
    push(f,     3'd1, 6'b100100);
    push(f + 1, 3'd2, 6'b000100);
    push(f + 2, 3'd3, 6'b011100);
    wait_cyc(f + 2);
    reset = 1'b1; run = 1'b0;
    m_pc = '0; m_ret = '0;
    push(f + 3, 3'd0, 6'b000100);
    wait_cyc(f + 3);
    reset = 1'b0;
    for (int i = 4; i < 8; i++) push(f + i, 3'd0, 6'b000100);
    wait_cyc(f + 8);
    chk("trace_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM that sequences the CPU datapath: ROM fetch, decode and condition check, ALU execute, and RAM/register writeback.
- Replaces the ad-hoc current_state/execute/chip_enable/rw driving in the CPU top level.
- Owns the program counter and a retired-instruction counter.
- Sits between ROM/RAM/ALU and the instruction decode fields.

Parameters:
- PC_W, 8, program counter width (ROM depth 2^PC_W)
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start request, sampled only in IDLE
- halt_req  in  1  stop after current instruction, sampled in WRITEBACK
- op_class  in  2  from decode: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
- cond  in  4  instruction condition field
- set_flags  in  1  ALU instruction updates flags
- flags  in  4  current flags {N,Z,C,V}
- branch_target  in  PC_W  absolute target for BRANCH
- pc  out  PC_W  ROM address
- rom_en  out  1  ROM read strobe
- alu_en  out  1  ALU execute strobe
- ram_ce  out  1  RAM chip enable
- ram_rw  out  1  1 = read, 0 = write
- reg_we  out  1  register/destination write strobe
- flag_we  out  1  flag register load strobe
- state  out  3  current FSM state, for debug/monitor
- retired  out  CNT_W  count of instructions that passed the condition check

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, pc = 0, retired = 0
  - all strobes = 0; ram_rw = 1
  - Reset asserted in any state aborts the instruction with no write strobes on the following cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- IDLE: no strobes. If run=1, go to FETCH; otherwise stay.
- FETCH: rom_en=1 for one cycle. ROM has 1-cycle read latency. Next state is DECODE.
- DECODE: op_class, cond, flags, set_flags and branch_target are valid this cycle.
  - If the condition fails: pc <= pc+1, next state FETCH, retired unchanged.
  - If the condition passes: next state EXECUTE.
- Condition codes (cond → requirement):
  - 0000 always
  - 0001 Z; 0010 !Z
  - 0011 C; 0100 !C
  - 0101 N; 0110 !N
  - 0111 V; 1000 !V
  - 1001–1111 never
- EXECUTE: alu_en=1 for all classes. For LOAD also ram_ce=1, ram_rw=1. Next state is WRITEBACK.
- WRITEBACK, per class:
  - ALU: reg_we=1, flag_we=set_flags
  - LOAD: reg_we=1
  - STORE: ram_ce=1, ram_rw=0 for exactly one cycle
  - BRANCH: no strobes
- WRITEBACK common actions:
  - retired <= retired+1 (wraps modulo 2^CNT_W).
  - PC update: BRANCH → pc <= branch_target; all other classes → pc <= pc+1.
  - Next state: HALT if halt_req=1, else FETCH.
- HALT: no strobes, pc and retired held. Exit only via reset; run is ignored.
- PC arithmetic is modulo 2^PC_W: 2^PC_W-1 + 1 → 0. A branch to the current pc is legal (tight loop).
- Latency:
  - Executed instruction: 4 cycles (FETCH to WRITEBACK).
  - Condition-failed instruction: 2 cycles.
- Strobe exclusivity: at most one of alu_en or reg_we, and at most one ram write, in any cycle.
- Outputs are registered from state and are glitch-free. flags are sampled only in DECODE; changes in other states are ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings
  - op_class codes
  - cond codes
  - flag bit indices (N=3, Z=2, C=1, V=0)
- One combinational sub-module, cond_eval (cond, flags → pass).
- FSM, pc and counter stay in cpu_sequencer.

Test Plan:
- Reset then run=1 with ALU, cond=0000, set_flags=1: state sequence 1,2,3,4,1. Expect rom_en in FETCH, alu_en in EXECUTE, reg_we and flag_we in WRITEBACK, then pc=1, retired=1.
- STORE, cond=0001, flags=0100 (Z set): ram_ce=1, ram_rw=0 for exactly one cycle in WRITEBACK; pc 0→1.
- Same STORE with flags=0000: after DECODE return to FETCH with no ram_ce and no alu_en; pc=1, retired=0; 2 cycles used.
- BRANCH with branch_target=0x20 at pc=5: pc=0x20 after WRITEBACK. Then ALU at pc=0xFF (PC_W=8): pc wraps to 0x00.
- halt_req=1 during WRITEBACK: state=5 next cycle, pc and retired frozen for 10 cycles despite run=1. A reset pulse returns to IDLE with pc=0, retired=0.
- Reset asserted during EXECUTE of a LOAD: next cycle state=0, all strobes 0, ram_rw=1, no reg_we ever issued.
